fifo_read_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It drives the dual-port FIFO storage read port (`addr_read`, `enable_read`) and synchronises the Gray-coded write pointer from the write domain. It computes empty, exports its own Gray-coded read pointer back to the write side, and presents words to the consumer through a valid/ready stream with a 3-entry prefetch buffer, giving full throughput.

---
 rtl/fifo_pkg.sv | 44 ++++
 rtl/ptr_sync.sv | 44 ++++
 rtl/fifo_read_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_read_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared constants and pointer helpers for the asynchronous FIFO
//           read and write controllers.
// Contents: FIFO_* default constants, prefetch-buffer index helper,
//           bin2gray / gray2bin conversion functions.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH  = 32;
  localparam int FIFO_ADDR_WIDTH  = 4;
  localparam int FIFO_SYNC_STAGES = 2;

  // Widest pointer the conversion helpers handle. Callers zero-extend their
  // pointer to this width and cast the result back down; zero upper bits stay
  // zero through both conversions, so one function serves every width.
  localparam int FIFO_PTR_MAX = 32;

  // Prefetch buffer geometry on the read side.
  localparam int FIFO_PF_DEPTH = 3;
  localparam int FIFO_PF_IDX_W = 2;

  function automatic logic [FIFO_PTR_MAX-1:0] bin2gray(input logic [FIFO_PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [FIFO_PTR_MAX-1:0] gray2bin(input logic [FIFO_PTR_MAX-1:0] gray);
    logic [FIFO_PTR_MAX-1:0] bin;
    bin[FIFO_PTR_MAX-1] = gray[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Circular index step for the 3-entry prefetch buffer (0 -> 1 -> 2 -> 0).
  function automatic logic [FIFO_PF_IDX_W-1:0] pf_next(input logic [FIFO_PF_IDX_W-1:0] idx);
    return (idx == FIFO_PF_IDX_W'(FIFO_PF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// ============================================================================
// Module  : ptr_sync
// Purpose : N-stage flop synchroniser for a Gray-coded pointer crossing into
//           this clock domain. Shared by the read and write controllers.
// Ports   : clk   - destination-domain clock
//           rst_n - asynchronous active-low reset, clears every stage
//           d     - pointer from the foreign domain (WIDTH bits)
//           q     - synchronised pointer (WIDTH bits)
// Params  : WIDTH  - pointer width
//           STAGES - number of flops in the chain, 2..4
// Revision: 1.0 - initial release
// ============================================================================
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Element 0 is the metastability-exposed first flop; the last element feeds
  // the destination logic.
  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_read_ctrl
// Purpose : Read-side controller of the asynchronous FIFO. Synchronises the
//           write pointer, derives empty, drives the storage read port and
//           streams words out through a 3-entry prefetch buffer at one word
//           per cycle.
// Ports   : clk, rst_n   - read clock, asynchronous active-low reset
//           wr_ptr_gray  - Gray write pointer from the write domain
//           rd_ptr_gray  - registered Gray read pointer to the write side
//           addr_read    - storage read address
//           enable_read  - storage read strobe (data one edge later)
//           mem_data     - storage read data
//           out_data     - head word of the prefetch buffer
//           out_valid    - out_data holds a word
//           out_ready    - consumer accepts on out_valid && out_ready
//           empty        - synchronised write pointer equals read pointer
// Revision: 1.0 - initial release
// ============================================================================
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int SYNC_STAGES = FIFO_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] addr_read,
  output logic                  enable_read,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_sync;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wr_ptr_gray),
    .q     (wr_sync)
  );

  logic [PTR_W-1:0]         rd_bin_q,  rd_bin_d;
  logic [PTR_W-1:0]         rd_gray_q, rd_gray_d;
  // Set on the issue edge: mem_data carries the requested word during the
  // following cycle and is pushed into the buffer on the edge after that.
  logic                     pend_q,    pend_d;
  logic [FIFO_PF_IDX_W-1:0] head_q,    head_d;
  logic [FIFO_PF_IDX_W-1:0] tail_q,    tail_d;
  logic [1:0]               buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0]    buf_q [FIFO_PF_DEPTH];
  logic [DATA_WIDTH-1:0]    buf_d [FIFO_PF_DEPTH];

  logic       push;
  logic       pop;
  logic [2:0] credit;

  assign empty       = (rd_gray_q == wr_sync);
  assign out_valid   = (buf_count_q != 2'd0);
  assign out_data    = buf_q[head_q];
  assign addr_read   = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray = rd_gray_q;

  assign push = pend_q;
  assign pop  = out_valid && out_ready;

  // Slots already spoken for: buffered words plus the word on its way. A word
  // popped this edge frees its slot in time for a new request, which is what
  // keeps throughput at one word per cycle without ever overflowing.
  assign credit      = {1'b0, buf_count_q} + {2'b00, pend_q} - {2'b00, pop};
  assign enable_read = !empty && (credit < 3'd3);

  always_comb begin
    rd_bin_d    = rd_bin_q + {{(PTR_W-1){1'b0}}, enable_read};
    rd_gray_d   = PTR_W'(bin2gray(FIFO_PTR_MAX'(rd_bin_d)));
    pend_d      = enable_read;
    head_d      = pop  ? pf_next(head_q) : head_q;
    tail_d      = push ? pf_next(tail_q) : tail_q;
    buf_count_d = buf_count_q;
    if (push && !pop) begin
      buf_count_d = buf_count_q + 2'd1;
    end else if (!push && pop) begin
      buf_count_d = buf_count_q - 2'd1;
    end
    buf_d = buf_q;
    if (push) begin
      buf_d[tail_q] = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      pend_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      buf_count_q <= '0;
      for (int i = 0; i < FIFO_PF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      pend_q      <= pend_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      buf_count_q <= buf_count_d;
      buf_q       <= buf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_read_ctrl
// Purpose : Self-checking bench for fifo_read_ctrl. Models the FIFO storage
//           and the write side, keeps the written words in a queue and checks
//           order, addresses, pointer values, latency and backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  wr_ptr_gray = '0;
  logic [4:0]  rd_ptr_gray;
  logic [3:0]  addr_read;
  logic        enable_read;
  logic [31:0] mem_data = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        empty;

  fifo_read_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .addr_read   (addr_read),
    .enable_read (enable_read),
    .mem_data    (mem_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // Storage: registered read port.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (enable_read) mem_data <= mem[addr_read];
  end

  int checks = 0;
  int errors = 0;
  int wptr   = 0;   // words written by the write side since reset
  int issued = 0;   // storage reads observed since reset
  int popped = 0;   // words accepted by the consumer since reset
  logic [31:0] exp_q [$];

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    mem[wptr % 16] = d;
    exp_q.push_back(d);
    wptr++;
    wr_ptr_gray = gray5(wptr);
  endtask

  // Called at a negedge. Observes the cycle's requests just before the rising
  // edge, then scores what that edge did.
  task automatic cycle();
    logic        pre_en, pre_pop;
    logic [3:0]  pre_addr;
    logic [31:0] pre_data;
    #1;
    pre_en   = enable_read;
    pre_pop  = out_valid && out_ready;
    pre_addr = addr_read;
    pre_data = out_data;
    @(posedge clk);
    #1;
    if (pre_pop) begin
      if (exp_q.size() == 0) check("pop_without_word", 1, 0);
      else check("out_data_order", pre_data, exp_q.pop_front());
      popped++;
    end
    if (pre_en) begin
      check("addr_read_seq", pre_addr, issued % 16);
      check("read_only_written", issued < wptr, 1);
      issued++;
    end
    check("rd_ptr_gray", rd_ptr_gray, gray5(issued));
    check("outstanding_le3", (issued - popped) <= 3, 1);
    @(negedge clk);
  endtask

  // Mid-cycle asynchronous reset; the write side is reset alongside.
  task automatic do_reset();
    #2;
    rst_n       = 1'b0;
    wr_ptr_gray = '0;
    out_ready   = 1'b0;
    #1;
    check("rst_empty",       empty,       1);
    check("rst_out_valid",   out_valid,   0);
    check("rst_addr_read",   addr_read,   0);
    check("rst_rd_ptr_gray", rd_ptr_gray, 0);
    check("rst_enable_read", enable_read, 0);
    check("rst_out_data",    out_data,    0);
    wptr = 0; issued = 0; popped = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;
    int gaps;
    bit seen;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    // ---- reset from power-up -------------------------------------------
    do_reset();

    // ---- single word: latency and pointer update -----------------------
    write_word(32'hDEADBEEF);
    cycle();                                   // E0
    check("e0_enable_read", enable_read, 0);
    cycle();                                   // E1: wr_sync updated
    check("e1_empty", empty, 0);
    check("e1_enable_read", enable_read, 1);
    check("e1_addr_read", addr_read, 0);
    cycle();                                   // E2: issue
    check("e2_rd_ptr_gray", rd_ptr_gray, 5'd1);
    check("e2_empty", empty, 1);
    check("e2_out_valid", out_valid, 0);
    cycle();                                   // E3: word buffered
    check("e3_out_valid", out_valid, 1);
    check("e3_out_data", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    cycle();
    check("single_popped", popped, 1);
    check("single_drained", out_valid, 0);

    // ---- full burst of 16 words, consumer always ready -----------------
    do_reset();
    for (int i = 0; i < 16; i++) write_word($urandom);
    check("burst_wr_gray", wr_ptr_gray, 5'b11000);
    out_ready = 1'b1;
    budget = 0; gaps = 0; seen = 0;
    while (popped < 16 && budget < 60) begin
      cycle();
      budget++;
      if (out_valid) seen = 1;
      else if (seen && popped < 16) gaps++;
    end
    check("burst_popped", popped, 16);
    check("burst_no_gaps", gaps, 0);
    check("burst_rd_ptr_gray", rd_ptr_gray, 5'b11000);
    check("burst_empty", empty, 1);
    check("burst_out_valid", out_valid, 0);

    // ---- backpressure: 10 words, consumer stalled ----------------------
    do_reset();
    for (int i = 0; i < 10; i++) write_word($urandom);
    for (int i = 0; i < 12; i++) cycle();
    check("bp_reads_issued", issued, 3);
    check("bp_buf_count", dut.buf_count_q, 3);
    check("bp_out_valid", out_valid, 1);
    check("bp_enable_read", enable_read, 0);
    out_ready = 1'b1;
    budget = 0;
    while (popped < 10 && budget < 40) begin
      cycle();
      budget++;
    end
    check("bp_popped", popped, 10);
    check("bp_issued_total", issued, 10);
    check("bp_queue_empty", exp_q.size(), 0);

    // ---- wrap-around: 20 words, random writer and consumer -------------
    do_reset();
    budget = 0;
    while (popped < 20 && budget < 400) begin
      if (wptr < 20 && (wptr - issued) < 16 && $urandom_range(0, 3) != 0)
        write_word($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      budget++;
    end
    check("wrap_popped", popped, 20);
    check("wrap_rd_ptr_gray", rd_ptr_gray, 5'b11110);
    check("wrap_msb_set", rd_ptr_gray[4], 1);

    // ---- reset with 2 words buffered and 1 in flight -------------------
    do_reset();
    for (int i = 0; i < 5; i++) write_word($urandom);
    budget = 0;
    while (issued < 3 && budget < 12) begin
      cycle();
      budget++;
    end
    check("mid_issued", issued, 3);
    check("mid_buffered", dut.buf_count_q, 2);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("post_rst_no_valid", out_valid, 0);
    end
    check("post_rst_no_reads", issued, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
